multicycle_control: RTL and testbench

Multicycle MIPS main controller, and the next generation of the single-cycle decoder. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. Memory is shared and stalls through a ready handshake. It drives the datapath muxes, register-file and memory strobes, and PC update for R-type, lw, sw, beq, j, jal, jr and (optionally) addi.

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_control_outdec.sv | 93 +++++++++
 rtl/multicycle_control.sv | 115 +++++++++++
 tb/tb_multicycle_control.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main controller:
// opcode/funct encodings, FSM state encoding and datapath mux encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_JR       = 4'd11,
    S_ADDI_EX  = 4'd12,
    S_ADDI_WB  = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Full set of state-decoded datapath controls
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       jal;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decoder: maps the current state (plus the effective memory
// ready for the handshake-dependent strobes) to the datapath control word.
// Everything is forced to zero while reset_n is low.
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       reset_n,
  output ctrl_t      ctrl
);

  // Per-state control decode; unlisted outputs stay at zero
  always_comb begin
    ctrl = '0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR, S_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctrl.i_or_d   = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl.i_or_d     = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_RTYPE_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RTYPE_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        S_JAL: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.reg_write  = 1'b1;
          ctrl.jal        = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JR: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_REGA;
          ctrl.instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM stepping each instruction
// through fetch/decode/execute/memory/writeback with a memory ready stall.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ADDI_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Jal,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOP,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t cur_state;
  state_t nxt_state;
  logic   is_store;
  logic   ready;
  logic   illegal_dec;
  ctrl_t  ctrl;

  // Without a handshake every access completes in one cycle
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next-state logic; opcode/funct only matter in DECODE
  always_comb begin
    nxt_state   = cur_state;
    illegal_dec = 1'b0;
    case (cur_state)
      S_FETCH:  if (ready) nxt_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = (funct == FUNCT_JR) ? S_JR : S_RTYPE_EX;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
          OP_JAL:       nxt_state = S_JAL;
          OP_ADDI: begin
            if (ADDI_EN) begin
              nxt_state = S_ADDI_EX;
            end else begin
              nxt_state   = S_FETCH;
              illegal_dec = 1'b1;
            end
          end
          default: begin
            nxt_state   = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR:   nxt_state = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (ready) nxt_state = S_MEMWB;
      S_MEMWR:    if (ready) nxt_state = S_FETCH;
      S_RTYPE_EX: nxt_state = S_RTYPE_WB;
      S_ADDI_EX:  nxt_state = S_ADDI_WB;
      default:    nxt_state = S_FETCH;
    endcase
  end

  // State register; lw/sw choice is latched in DECODE since opcode is not held later
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
      is_store  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) is_store <= (opcode == OP_SW);
    end
  end

  multicycle_ctrl_outdec u_outdec (
    .state     (cur_state),
    .mem_ready (ready),
    .reset_n   (reset_n),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign Jal         = ctrl.jal;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign AluOP       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = reset_n & illegal_dec;
  assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a scoreboard,
// plus a hand-written addi sequence on a second instance with ADDI_EN=1.
`timescale 1ns/1ps
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b1;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic RegDst, RegWrite, ALUSrcA, Jal, instr_done, illegal_op;
  logic [1:0] ALUSrcB, AluOP, PCSource;
  logic [3:0] state;

  logic a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_MemtoReg;
  logic a_RegDst, a_RegWrite, a_ALUSrcA, a_Jal, a_instr_done, a_illegal_op;
  logic [1:0] a_ALUSrcB, a_AluOP, a_PCSource;
  logic [3:0] a_state;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ADDI_EN(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Jal(Jal), .ALUSrcB(ALUSrcB), .AluOP(AluOP),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ADDI_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .IorD(a_IorD), .MemRead(a_MemRead),
    .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .MemtoReg(a_MemtoReg), .RegDst(a_RegDst),
    .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA), .Jal(a_Jal), .ALUSrcB(a_ALUSrcB),
    .AluOP(a_AluOP), .PCSource(a_PCSource), .instr_done(a_instr_done),
    .illegal_op(a_illegal_op), .state(a_state)
  );

  // Output word: pcw pcwc iord mr | mw irw m2r rd | rw asa jal, asb, aop, pcs, done, ill
  logic [18:0] out_d, out_a;
  assign out_d = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, Jal, ALUSrcB, AluOP, PCSource, instr_done, illegal_op};
  assign out_a = {a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite, a_IRWrite,
                  a_MemtoReg, a_RegDst, a_RegWrite, a_ALUSrcA, a_Jal, a_ALUSrcB, a_AluOP,
                  a_PCSource, a_instr_done, a_illegal_op};

  localparam logic [18:0] O_RST        = 19'd0;
  localparam logic [18:0] O_FETCH_WAIT = {11'b0001_0000_000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_FETCH_GO   = {11'b1001_0100_000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_DECODE     = {11'b0000_0000_000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_DECODE_ILL = {11'b0000_0000_000, 2'b11, 2'b00, 2'b00, 2'b01};
  localparam logic [18:0] O_MEMADR     = {11'b0000_0000_010, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_MEMRD      = {11'b0011_0000_000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_MEMWB      = {11'b0000_0010_100, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] O_MEMWR_WAIT = {11'b0010_1000_000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_MEMWR_GO   = {11'b0010_1000_000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] O_RTYPE_EX   = {11'b0000_0000_010, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [18:0] O_RTYPE_WB   = {11'b0000_0001_100, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] O_BRANCH     = {11'b0100_0000_010, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [18:0] O_JUMP       = {11'b1000_0000_000, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [18:0] O_JAL        = {11'b1000_0000_101, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [18:0] O_JR         = {11'b1000_0000_000, 2'b00, 2'b00, 2'b11, 2'b10};
  localparam logic [18:0] O_ADDI_EX    = {11'b0000_0000_010, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] O_ADDI_WB    = {11'b0000_0000_100, 2'b00, 2'b00, 2'b00, 2'b10};

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    string      name;
    logic       rn;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic [3:0] st;
    logic [18:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    bit         alt;
    logic [3:0] st;
    logic [18:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string name, input logic rn, input logic [5:0] op,
                     input logic [5:0] fn, input logic rdy, input state_t st,
                     input logic [18:0] exp);
    vecs.push_back('{name, rn, op, fn, rdy, 4'(st), exp});
  endtask

  // Drive one cycle of inputs just after the edge and queue what that cycle must show
  task automatic drive(input string name, input bit alt, input logic rn, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy, input logic [3:0] st,
                       input logic [18:0] exp);
    @(posedge clk);
    #1;
    reset_n   = rn;
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    sb.push_back('{name, alt, st, exp});
  endtask

  // Scoreboard checker: compare on the falling edge, mid-cycle
  sb_t        e;
  logic [3:0] act_st;
  logic [18:0] act_out;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e       = sb.pop_front();
      act_st  = e.alt ? a_state : state;
      act_out = e.alt ? out_a : out_d;
      n_vec++;
      if (act_st !== e.st || act_out !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got state=%0d out=%b, required state=%0d out=%b",
                 e.name, act_st, act_out, e.st, e.exp);
      end
    end
  end

  initial begin
    // reset state
    add("rst",      0, OP_LW, 0, 1, S_FETCH,  O_RST);
    // lw, zero wait states: 5 cycles
    add("lw_f",     1, OP_LW, 0, 1, S_FETCH,  O_FETCH_GO);
    add("lw_d",     1, OP_LW, 0, 1, S_DECODE, O_DECODE);
    add("lw_a",     1, OP_LW, 0, 1, S_MEMADR, O_MEMADR);
    add("lw_r",     1, OP_LW, 0, 1, S_MEMRD,  O_MEMRD);
    add("lw_wb",    1, OP_LW, 0, 1, S_MEMWB,  O_MEMWB);
    // sw with one fetch wait and two MEMWR waits; opcode changes after DECODE
    add("sw_fw",    1, OP_SW, 0, 0, S_FETCH,  O_FETCH_WAIT);
    add("sw_f",     1, OP_SW, 0, 1, S_FETCH,  O_FETCH_GO);
    add("sw_d",     1, OP_SW, 0, 1, S_DECODE, O_DECODE);
    add("sw_a",     1, OP_LW, 0, 1, S_MEMADR, O_MEMADR);
    add("sw_w0",    1, OP_LW, 0, 0, S_MEMWR,  O_MEMWR_WAIT);
    add("sw_w1",    1, OP_LW, 0, 0, S_MEMWR,  O_MEMWR_WAIT);
    add("sw_w2",    1, OP_LW, 0, 1, S_MEMWR,  O_MEMWR_GO);
    // R-type add
    add("add_f",    1, OP_RTYPE, F_ADD, 1, S_FETCH,    O_FETCH_GO);
    add("add_d",    1, OP_RTYPE, F_ADD, 1, S_DECODE,   O_DECODE);
    add("add_ex",   1, OP_RTYPE, F_ADD, 1, S_RTYPE_EX, O_RTYPE_EX);
    add("add_wb",   1, OP_RTYPE, F_ADD, 1, S_RTYPE_WB, O_RTYPE_WB);
    // jr
    add("jr_f",     1, OP_RTYPE, FUNCT_JR, 1, S_FETCH,  O_FETCH_GO);
    add("jr_d",     1, OP_RTYPE, FUNCT_JR, 1, S_DECODE, O_DECODE);
    add("jr_x",     1, OP_RTYPE, FUNCT_JR, 1, S_JR,     O_JR);
    // jal
    add("jal_f",    1, OP_JAL, 0, 1, S_FETCH,  O_FETCH_GO);
    add("jal_d",    1, OP_JAL, 0, 1, S_DECODE, O_DECODE);
    add("jal_x",    1, OP_JAL, 0, 1, S_JAL,    O_JAL);
    // beq
    add("beq_f",    1, OP_BEQ, 0, 1, S_FETCH,  O_FETCH_GO);
    add("beq_d",    1, OP_BEQ, 0, 1, S_DECODE, O_DECODE);
    add("beq_x",    1, OP_BEQ, 0, 1, S_BRANCH, O_BRANCH);
    // j, with mem_ready low where it must be ignored
    add("j_f",      1, OP_J, 0, 1, S_FETCH,  O_FETCH_GO);
    add("j_d",      1, OP_J, 0, 0, S_DECODE, O_DECODE);
    add("j_x",      1, OP_J, 0, 0, S_JUMP,   O_JUMP);
    // illegal opcode
    add("ill_f",    1, OP_BAD, 0, 1, S_FETCH,  O_FETCH_GO);
    add("ill_d",    1, OP_BAD, 0, 1, S_DECODE, O_DECODE_ILL);
    add("ill_nx",   1, OP_BAD, 0, 0, S_FETCH,  O_FETCH_WAIT);
    // addi with ADDI_EN=0 is illegal
    add("addi0_f",  1, OP_ADDI, 0, 1, S_FETCH,  O_FETCH_GO);
    add("addi0_d",  1, OP_ADDI, 0, 1, S_DECODE, O_DECODE_ILL);
    add("addi0_nx", 1, OP_ADDI, 0, 0, S_FETCH,  O_FETCH_WAIT);
    // lw with a MEMRD wait, then reset mid-instruction
    add("rlw_f",    1, OP_LW, 0, 1, S_FETCH,  O_FETCH_GO);
    add("rlw_d",    1, OP_LW, 0, 1, S_DECODE, O_DECODE);
    add("rlw_a",    1, OP_LW, 0, 1, S_MEMADR, O_MEMADR);
    add("rlw_rw",   1, OP_LW, 0, 0, S_MEMRD,  O_MEMRD);
    add("rlw_rst",  0, OP_LW, 0, 1, S_MEMRD,  O_RST);
    add("rlw_rst2", 0, OP_LW, 0, 1, S_FETCH,  O_RST);
    add("rlw_f2",   1, OP_LW, 0, 1, S_FETCH,  O_FETCH_GO);
    add("rlw_d2",   1, OP_LW, 0, 1, S_DECODE, O_DECODE);
    add("rlw_a2",   1, OP_LW, 0, 1, S_MEMADR, O_MEMADR);
    add("rlw_r2",   1, OP_LW, 0, 1, S_MEMRD,  O_MEMRD);
    add("rlw_wb2",  1, OP_LW, 0, 1, S_MEMWB,  O_MEMWB);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].name, 1'b0, vecs[i].rn, vecs[i].op, vecs[i].fn, vecs[i].rdy,
            vecs[i].st, vecs[i].exp);

    // addi on the ADDI_EN=1 instance, after a reset to resynchronise it
    drive("a_rst",  1'b1, 1'b0, OP_ADDI, 6'd0, 1'b1, 4'(S_FETCH),   O_RST);
    drive("a_f",    1'b1, 1'b1, OP_ADDI, 6'd0, 1'b1, 4'(S_FETCH),   O_FETCH_GO);
    drive("a_d",    1'b1, 1'b1, OP_ADDI, 6'd0, 1'b1, 4'(S_DECODE),  O_DECODE);
    drive("a_ex",   1'b1, 1'b1, OP_ADDI, 6'd0, 1'b1, 4'(S_ADDI_EX), O_ADDI_EX);
    drive("a_wb",   1'b1, 1'b1, OP_ADDI, 6'd0, 1'b1, 4'(S_ADDI_WB), O_ADDI_WB);
    drive("a_nx",   1'b1, 1'b1, OP_ADDI, 6'd0, 1'b0, 4'(S_FETCH),   O_FETCH_WAIT);
    // reset asserted during MEMWR wait: no write strobe while reset is low
    drive("a_sw_f", 1'b1, 1'b1, OP_SW, 6'd0, 1'b1, 4'(S_FETCH),  O_FETCH_GO);
    drive("a_sw_d", 1'b1, 1'b1, OP_SW, 6'd0, 1'b1, 4'(S_DECODE), O_DECODE);
    drive("a_sw_a", 1'b1, 1'b1, OP_SW, 6'd0, 1'b1, 4'(S_MEMADR), O_MEMADR);
    drive("a_sw_w", 1'b1, 1'b1, OP_SW, 6'd0, 1'b0, 4'(S_MEMWR),  O_MEMWR_WAIT);
    drive("a_sw_r", 1'b1, 1'b0, OP_SW, 6'd0, 1'b1, 4'(S_MEMWR),  O_RST);
    drive("a_sw_x", 1'b1, 1'b1, OP_SW, 6'd0, 1'b1, 4'(S_FETCH),  O_FETCH_GO);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
